// File: rtl/midi_note_tracker_pkg.sv
// Shared MIDI constants, note-stack entry type and message classification for midi_note_tracker.
// MIDI_SUSTAIN_PEDAL_EN adds sustain-pedal (CC64) classification.
package midi_note_tracker_pkg;

    typedef logic [7:0] midi_byte_t;

    localparam logic [3:0] MidiStatusNoteOn  = 4'h9;
    localparam logic [3:0] MidiStatusNoteOff = 4'h8;
    localparam logic [3:0] MidiStatusCc      = 4'hB;
    localparam logic [6:0] MidiCcAllNotesOff = 7'd123;
    localparam logic [6:0] MidiCcSustain     = 7'd64;

    typedef struct packed {
        logic       valid;
        logic [6:0] note;
        logic [6:0] vel;
    } note_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_REMOVE,
        ST_MAKEROOM,
        ST_PUSH,
        ST_UPDATE
    } state_t;

    typedef enum logic [2:0] {
        MSG_IGNORE,
        MSG_ON,
        MSG_OFF,
        MSG_ALL_OFF,
        MSG_PEDAL
    } msg_kind_t;

    function automatic msg_kind_t classify(input logic [3:0] status_hi, input logic [6:0] data1,
                                           input logic [6:0] data2, input logic [1:0] len);
        msg_kind_t kind;
        kind = MSG_IGNORE;
        if (len == 2'd3) begin
            if (status_hi == MidiStatusNoteOn)
                kind = (data2 != 7'd0) ? MSG_ON : MSG_OFF;
            else if (status_hi == MidiStatusNoteOff)
                kind = MSG_OFF;
            else if (status_hi == MidiStatusCc && data1 == MidiCcAllNotesOff)
                kind = MSG_ALL_OFF;
`ifdef MIDI_SUSTAIN_PEDAL_EN
            else if (status_hi == MidiStatusCc && data1 == MidiCcSustain)
                kind = MSG_PEDAL;
`endif
        end
        return kind;
    endfunction

endpackage

// File: rtl/midi_note_tracker_note_stack.sv
// Note storage for midi_note_tracker: index-addressed read, shift-down, invalidate, write and clear.
module note_stack
    import midi_note_tracker_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] rd_idx,
    output note_entry_t   rd_entry,
    input  logic [IW-1:0] cmd_idx,
    input  logic          shift_en,
    input  logic          inval_en,
    input  logic          wr_en,
    input  note_entry_t   wr_entry,
    input  logic          clear_en
);

    note_entry_t mem [DEPTH];

    // A shift copies entry idx+1 down and invalidates its old slot, so the last shift leaves the top empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
        end else if (shift_en) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                if (cmd_idx == IW'(i)) begin
                    mem[i]         <= mem[i+1];
                    mem[i+1].valid <= 1'b0;
                end
            end
        end else if (inval_en) begin
            mem[cmd_idx].valid <= 1'b0;
        end else if (wr_en) begin
            mem[cmd_idx] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/midi_note_tracker.sv
// Last-note-priority monophonic note tracker driving gate/note/velocity/trigger to the voice stage.
// MIDI_SUSTAIN_PEDAL_EN enables CC64 sustain-pedal handling.
module midi_note_tracker
    import midi_note_tracker_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                       i_clk_aud,
    input  logic                       i_aud_rst_n,
    input  logic                       i_msg_valid,
    input  logic [1:0]                 i_msg_len,
    input  midi_byte_t [2:0]           i_msg,
    output logic                       o_gate,
    output logic [6:0]                 o_note,
    output logic [6:0]                 o_velocity,
    output logic                       o_trigger,
    output logic                       o_busy,
    output logic                       o_overrun,
    output logic [$clog2(Depth+1)-1:0] o_count
);

    localparam int unsigned CW = $clog2(Depth + 1);
    localparam int unsigned IW = $clog2(Depth);

    state_t      state, next_state;
    msg_kind_t   kind_in;
    logic [CW-1:0] count, idx;
    logic        msg_is_on, from_push;
    logic [6:0]  msg_note, msg_vel;
    logic        gate, trigger, overrun;
    logic [6:0]  note, vel;
    logic        last_step, idx_is_top, exhausted, match;
    logic [IW-1:0] rd_idx, cmd_idx;
    logic        shift_en, inval_en, wr_en, clear_en;
    note_entry_t rd_entry, wr_entry;
    logic        unused_bits;
`ifdef MIDI_SUSTAIN_PEDAL_EN
    logic        pedal;
`endif

    // Channel nibble is filtered upstream and data-byte MSBs are always zero.
    assign unused_bits = ^{i_msg[0][3:0], i_msg[1][7], i_msg[2][7]};
    assign kind_in     = classify(i_msg[0][7:4], i_msg[1][6:0], i_msg[2][6:0], i_msg_len);

    always_comb begin
        last_step  = ({1'b0, idx} + (CW+1)'(2)) >= {1'b0, count};
        idx_is_top = idx == (count - CW'(1));
        exhausted  = idx >= count;
        match      = rd_entry.valid && (rd_entry.note == msg_note);
    end

    always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
        if (!i_aud_rst_n) state <= ST_IDLE;
        else              state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (i_msg_valid) begin
                    case (kind_in)
                        MSG_ON, MSG_OFF:        next_state = ST_SEARCH;
                        MSG_ALL_OFF, MSG_PEDAL: next_state = ST_UPDATE;
                        default:                next_state = ST_IDLE;
                    endcase
                end
            end
            ST_SEARCH: begin
                if (exhausted) begin
                    if (!msg_is_on)                next_state = ST_IDLE;
                    else if (count == CW'(Depth))  next_state = ST_MAKEROOM;
                    else                           next_state = ST_PUSH;
                end else if (match) begin
                    next_state = ST_REMOVE;
                end
            end
            ST_REMOVE:   if (last_step) next_state = msg_is_on ? ST_PUSH : ST_UPDATE;
            ST_MAKEROOM: if (last_step) next_state = ST_PUSH;
            ST_PUSH:     next_state = ST_UPDATE;
            ST_UPDATE:   next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = state != ST_IDLE;
        clear_en = (state == ST_IDLE) && i_msg_valid && (kind_in == MSG_ALL_OFF);
        shift_en = ((state == ST_REMOVE) && !idx_is_top) || (state == ST_MAKEROOM);
        inval_en = (state == ST_REMOVE) && idx_is_top;
        wr_en    = state == ST_PUSH;
        wr_entry = '{valid: 1'b1, note: msg_note, vel: msg_vel};
        cmd_idx  = (state == ST_PUSH) ? IW'(count) : IW'(idx);
        rd_idx   = (state == ST_UPDATE) ? IW'(count - CW'(1)) : IW'(idx);
    end

    note_stack #(.DEPTH(Depth)) u_stack (
        .clk      (i_clk_aud),
        .rst_n    (i_aud_rst_n),
        .rd_idx   (rd_idx),
        .rd_entry (rd_entry),
        .cmd_idx  (cmd_idx),
        .shift_en (shift_en),
        .inval_en (inval_en),
        .wr_en    (wr_en),
        .wr_entry (wr_entry),
        .clear_en (clear_en)
    );

    always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
        if (!i_aud_rst_n) begin
            count     <= '0;
            idx       <= '0;
            msg_is_on <= 1'b0;
            msg_note  <= '0;
            msg_vel   <= '0;
            from_push <= 1'b0;
            gate      <= 1'b0;
            note      <= '0;
            vel       <= '0;
            trigger   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            trigger <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_msg_valid) begin
                        msg_is_on <= kind_in == MSG_ON;
                        msg_note  <= i_msg[1][6:0];
                        msg_vel   <= i_msg[2][6:0];
                        idx       <= '0;
                        from_push <= 1'b0;
                        if (kind_in == MSG_ALL_OFF) count <= '0;
                    end
                end
                ST_SEARCH: begin
                    if (exhausted)   idx <= '0;
                    else if (!match) idx <= idx + CW'(1);
                end
                ST_REMOVE, ST_MAKEROOM: begin
                    if (last_step) begin
                        count <= count - CW'(1);
                        idx   <= '0;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                ST_PUSH: begin
                    count     <= count + CW'(1);
                    from_push <= 1'b1;
                end
                ST_UPDATE: begin
                    if (count != '0) begin
                        gate    <= 1'b1;
                        note    <= rd_entry.note;
                        vel     <= rd_entry.vel;
                        trigger <= from_push;
                    end else begin
`ifdef MIDI_SUSTAIN_PEDAL_EN
                        gate <= gate & pedal;
`else
                        gate <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
            if (i_msg_valid && state != ST_IDLE) overrun <= 1'b1;
        end
    end

`ifdef MIDI_SUSTAIN_PEDAL_EN
    always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
        if (!i_aud_rst_n)
            pedal <= 1'b0;
        else if (state == ST_IDLE && i_msg_valid && kind_in == MSG_PEDAL)
            pedal <= i_msg[2][6:0] >= MidiCcSustain;
    end
`endif

    assign o_gate     = gate;
    assign o_note     = note;
    assign o_velocity = vel;
    assign o_trigger  = trigger;
    assign o_overrun  = overrun;
    assign o_count    = count;

endmodule

// File: tb/tb_midi_note_tracker.sv
// Scoreboard bench for midi_note_tracker: directed scenarios plus random traffic against a queue-based model.
module tb_midi_note_tracker;
    import midi_note_tracker_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LAT   = 2 * DEPTH + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             msg_valid = 1'b0;
    logic [1:0]       msg_len = '0;
    midi_byte_t [2:0] msg = '0;
    logic             o_gate, o_trigger, o_busy, o_overrun;
    logic [6:0]       o_note, o_velocity;
    logic [CW-1:0]    o_count;

    always #5 clk = ~clk;

    midi_note_tracker #(.Depth(DEPTH)) dut (
        .i_clk_aud   (clk),
        .i_aud_rst_n (rst_n),
        .i_msg_valid (msg_valid),
        .i_msg_len   (msg_len),
        .i_msg       (msg),
        .o_gate      (o_gate),
        .o_note      (o_note),
        .o_velocity  (o_velocity),
        .o_trigger   (o_trigger),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun),
        .o_count     (o_count)
    );

    typedef struct {int gate; int note; int vel; int trig; int count; int overrun;} exp_t;
    typedef struct {int note; int vel;} held_t;

    exp_t  exp_q[$];
    held_t stk[$];
    int    m_gate, m_note, m_vel, m_pedal, m_overrun;
    int    checks, errors;
    logic  prev_busy = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int find_note(input int n);
        for (int i = 0; i < stk.size(); i++) if (stk[i].note == n) return i;
        return -1;
    endfunction

    function automatic void model_top();
        if (stk.size() > 0) begin
            m_gate = 1;
            m_note = stk[stk.size()-1].note;
            m_vel  = stk[stk.size()-1].vel;
        end else if (m_pedal == 0) begin
            m_gate = 0;
        end
    endfunction

    function automatic void model_reset();
        stk.delete();
        exp_q.delete();
        m_gate = 0; m_note = 0; m_vel = 0; m_pedal = 0; m_overrun = 0;
    endfunction

    // Apply one message to the model, queue its expected result, drive it and wait for the FSM.
    task automatic send(input logic [7:0] st, input int d1, input int d2, input int len, input bit drop = 0);
        bit on, off, all, ped, done;
        int pos;
        on  = (st[7:4] == 4'h9) && (len == 3) && (d2 != 0);
        off = (len == 3) && ((st[7:4] == 4'h8) || (st[7:4] == 4'h9 && d2 == 0));
        all = (st[7:4] == 4'hB) && (len == 3) && (d1 == 123);
`ifdef MIDI_SUSTAIN_PEDAL_EN
        ped = (st[7:4] == 4'hB) && (len == 3) && (d1 == 64);
`else
        ped = 1'b0;
`endif
        pos = find_note(d1);
        if (on) begin
            if (pos >= 0) stk.delete(pos);
            if (stk.size() == DEPTH) void'(stk.pop_front());
            stk.push_back('{d1, d2});
            model_top();
        end else if (off && pos >= 0) begin
            stk.delete(pos);
            model_top();
        end else if (all) begin
            stk.delete();
            model_top();
        end else if (ped) begin
            m_pedal = (d2 >= 64) ? 1 : 0;
            model_top();
        end
        if (drop) m_overrun = 1;
        if (on || off || all || ped)
            exp_q.push_back('{m_gate, m_note, m_vel, int'(on), stk.size(), m_overrun});

        msg       = {8'(d2), 8'(d1), st};
        msg_len   = 2'(len);
        msg_valid = 1'b1;
        if (!(on || off || all || ped)) begin
            @(negedge clk);
            msg_valid = 1'b0;
            @(negedge clk);
            return;
        end
        done = 1'b0;
        for (int k = 1; k <= LAT && !done; k++) begin
            @(negedge clk);
            if (k == 1 && drop) begin
                msg     = {8'd70, 8'd70, 8'h90};
                msg_len = 2'd3;
            end else begin
                msg_valid = 1'b0;
            end
            if (!o_busy) begin
                done = 1'b1;
                msg_valid = 1'b0;
            end
        end
        msg_valid = 1'b0;
        chk("latency_bound", int'(done), 1);
        if (!done) begin
            for (int k = 0; k < 4 * DEPTH && o_busy; k++) @(negedge clk);
        end
    endtask

    // Monitor: each busy->idle transition presents a result to compare with the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !o_busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("gate", int'(o_gate), e.gate);
                        chk("note", int'(o_note), e.note);
                        chk("velocity", int'(o_velocity), e.vel);
                        chk("trigger", int'(o_trigger), e.trig);
                        chk("count", int'(o_count), e.count);
                        chk("overrun", int'(o_overrun), e.overrun);
                    end
                end else begin
                    chk("trigger_idle", int'(o_trigger), 0);
                end
                prev_busy = o_busy;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, n, v;
        logic [7:0] st;
        checks = 0;
        errors = 0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_gate", int'(o_gate), 0);
        chk("rst_note", int'(o_note), 0);
        chk("rst_vel", int'(o_velocity), 0);
        chk("rst_trigger", int'(o_trigger), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_overrun", int'(o_overrun), 0);
        chk("rst_count", int'(o_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(8'h90, 60, 100, 3);
        chk("tp1_gate", int'(o_gate), 1);
        chk("tp1_note", int'(o_note), 60);
        chk("tp1_vel", int'(o_velocity), 100);
        chk("tp1_count", int'(o_count), 1);

        send(8'h90, 64, 90, 3);
        send(8'h80, 64, 0, 3);
        chk("tp2_note", int'(o_note), 60);
        chk("tp2_vel", int'(o_velocity), 100);
        chk("tp2_gate", int'(o_gate), 1);
        send(8'h80, 60, 0, 3);
        chk("tp2_gate_off", int'(o_gate), 0);
        chk("tp2_note_hold", int'(o_note), 60);

        send(8'h90, 60, 100, 3);
        send(8'h90, 60, 0, 3);
        chk("tp3_gate", int'(o_gate), 0);
        chk("tp3_count", int'(o_count), 0);

        for (int i = 0; i <= DEPTH; i++) send(8'h91, 40 + i, 80, 3);
        chk("tp4_count", int'(o_count), DEPTH);
        chk("tp4_note", int'(o_note), 40 + DEPTH);
        for (int i = DEPTH; i >= 2; i--) send(8'h81, 40 + i, 0, 3);
        chk("tp4_oldest_dropped", int'(o_note), 41);
        send(8'h81, 41, 0, 3);
        chk("tp4_gate", int'(o_gate), 0);
        send(8'h81, 40, 0, 3);
        chk("tp4_empty_off", int'(o_count), 0);

        send(8'h90, 50, 10, 3);
        send(8'h90, 51, 20, 3);
        send(8'h90, 52, 30, 3);
        send(8'hB0, 123, 0, 3, 1'b1);
        chk("tp5_count", int'(o_count), 0);
        chk("tp5_gate", int'(o_gate), 0);
        chk("tp5_overrun", int'(o_overrun), 1);

        send(8'h90, 60, 100, 3);
        send(8'hB0, 64, 127, 3);
        send(8'h80, 60, 0, 3);
`ifdef MIDI_SUSTAIN_PEDAL_EN
        chk("tp6_pedal_hold", int'(o_gate), 1);
`else
        chk("tp6_no_pedal", int'(o_gate), 0);
`endif
        send(8'hB0, 64, 0, 3);
        chk("tp6_pedal_up", int'(o_gate), 0);

        send(8'hA0, 61, 10, 3);
        send(8'h90, 61, 100, 2);
        send(8'hB0, 123, 0, 2);
        chk("ignored_count", int'(o_count), 0);

        for (int it = 0; it < 500; it++) begin
            r  = $urandom_range(0, 99);
            n  = $urandom_range(36, 47);
            v  = $urandom_range(0, 127);
            st = {4'h0, 4'($urandom_range(0, 15))};
            if (r < 45)      send({4'h9, st[3:0]}, n, v, ($urandom_range(0, 9) == 0) ? 2 : 3);
            else if (r < 78) send({4'h8, st[3:0]}, n, v, 3);
            else if (r < 83) send({4'hB, st[3:0]}, 123, 0, 3);
            else if (r < 93) send({4'hB, st[3:0]}, 64, v, 3);
            else             send({4'hE, st[3:0]}, n, v, 3);
        end

        msg       = {8'd50, 8'd77, 8'h90};
        msg_len   = 2'd3;
        msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_gate", int'(o_gate), 0);
        chk("midrst_count", int'(o_count), 0);
        chk("midrst_overrun", int'(o_overrun), 0);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h90, 20, 30, 3);
        chk("post_rst_count", int'(o_count), 1);
        chk("post_rst_note", int'(o_note), 20);

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_note_tracker.md
Name: midi_note_tracker

Overview:
- Consumes complete MIDI messages from midi_reader in the audio clock domain.
- Maintains a last-note-priority note stack for a monophonic voice.
- Drives gate, current note, velocity and a trigger pulse to the downstream voice/oscillator stage, replacing the fixed test-tone FCW.
- Has no back-pressure path: messages arriving while busy are dropped and flagged.

Parameters:
- Depth, 8, number of held notes tracked; legal range 2..16.

Ports:
- i_clk_aud  input  1  audio/MIDI clock (single clock domain)
- i_aud_rst_n  input  1  asynchronous active-low reset
- i_msg_valid  input  1  one-cycle strobe: i_msg/i_msg_len are valid
- i_msg_len  input  2  number of valid bytes in i_msg (1..3)
- i_msg  input  3x midi_byte_t  status, data1, data2
- o_gate  output  1  high while at least one note is held
- o_note  output  7  current (top-of-stack) note number
- o_velocity  output  7  velocity of the current note
- o_trigger  output  1  one-cycle pulse when a note-on becomes the top note
- o_busy  output  1  high while the FSM is not IDLE
- o_overrun  output  1  sticky: a message was dropped while busy
- o_count  output  $clog2(Depth+1)  number of held notes

Behaviour:
- Reset values: o_gate=0, o_note=0, o_velocity=0, o_trigger=0, o_busy=0, o_overrun=0, o_count=0. All stack entries are invalid.
- Reset mid-operation aborts the FSM immediately with no partial commit.
- Classification in IDLE on i_msg_valid, with the message latched:
  - NOTE_ON: status[7:4]=9, len=3, data2>0.
  - NOTE_OFF: status[7:4]=8 with len=3, or NOTE_ON with data2=0.
  - ALL_OFF: status[7:4]=B, len=3, data1=123.
  - Any other message is ignored and the FSM stays IDLE.
  - Channel filtering is done upstream; the low nibble is ignored.
- FSM states: IDLE, SEARCH, REMOVE, MAKEROOM, PUSH, UPDATE.
- SEARCH:
  - Index 0..count-1, one entry per cycle.
  - On a note match, go to REMOVE.
  - On exhausting the entries: NOTE_ON goes to MAKEROOM; NOTE_OFF goes to IDLE with no output change.
- REMOVE:
  - Entries i..count-2 take entry i+1, one per cycle, then count decrements.
  - Then: NOTE_ON goes to MAKEROOM; NOTE_OFF goes to UPDATE.
- MAKEROOM:
  - If count==Depth, shift the whole stack down one entry, discarding the oldest at index 0, then count decrements (one cycle per entry).
  - Otherwise zero cycles.
  - Then go to PUSH.
- PUSH: write {note, velocity} at index count, increment count, go to UPDATE.
- ALL_OFF: clear all valid bits in one cycle, set count=0, go to UPDATE.
- UPDATE:
  - If count>0: o_gate=1, o_note/o_velocity take the top entry.
  - If count==0: o_gate=0 and o_note/o_velocity hold their last values for the release phase.
  - o_trigger pulses in UPDATE only when the path came from PUSH.
  - Returns to IDLE.
- Duplicate note-on (same note already held): the entry is moved to the top with the new velocity, and o_trigger pulses.
- Latency: at most 2*Depth+3 cycles from i_msg_valid to the outputs updating. This is far below the MIDI byte time, so drops occur only under fault stimulus.
- i_msg_valid while o_busy=1: the message is dropped and o_overrun is set. o_overrun clears only on reset.
- Stack empty on NOTE_OFF: SEARCH takes 0 cycles and the FSM returns to IDLE.

Optional Feature:
- Macro: MIDI_SUSTAIN_PEDAL_EN.
- With the macro: CC64 (status B, data1=64, len 3) sets the pedal state to data2>=64.
  - While the pedal is down, a NOTE_OFF or ALL_OFF that would empty the stack leaves o_gate=1 and o_note unchanged.
  - A pedal-up event with count==0 drives o_gate=0 one cycle after the message (via UPDATE).
  - Reset clears the pedal state.
- Without the macro: CC64 is ignored like any other CC, and no pedal register exists.

Decomposition:
- Shared package/types.svh:
  - Add MidiStatusNoteOn=4'h9, MidiStatusNoteOff=4'h8, MidiStatusCc=4'hB, MidiCcAllNotesOff=7'd123, MidiCcSustain=7'd64.
  - Add note_entry_t struct {logic valid; logic [6:0] note; logic [6:0] vel}.
- Reuse midi_byte_t.
- One sub-module: note_stack. It holds the storage array and executes index-addressed read, shift-down-from-index and write-at-top commands. The FSM and classification stay in midi_note_tracker.

Test Plan:
- Reset then NOTE_ON 0x90 60 100 -> within 2*Depth+3 cycles: o_gate=1, o_note=60, o_velocity=100, exactly one o_trigger pulse, o_count=1.
- ON 60/100, ON 64/90, OFF 64 -> o_note returns to 60 with o_velocity=100, o_gate stays 1, and no trigger on the release. Then OFF 60 -> o_gate=0 and o_note holds 60.
- 0x90 60 0 after ON 60 -> treated as note-off: o_gate=0, o_count=0.
- Depth+1 distinct note-ons (notes 40..48, Depth=8) -> o_count=8, o_note=48. Then OFF 48 through 42 -> final o_note=41 (note 40 was discarded), and OFF 41 -> o_gate=0.
- 0xB0 123 0 with 3 notes held -> o_count=0, o_gate=0. A second i_msg_valid asserted while o_busy=1 -> o_overrun=1, and the second message has no effect.
- MIDI_SUSTAIN_PEDAL_EN: ON 60, CC64=127, OFF 60 -> o_gate stays 1. Then CC64=0 -> o_gate=0. Without the macro, the same stimulus drops o_gate at the OFF.
